sample_loader: RTL and testbench
================================

# sample_loader

Feeds the 60-input mine-detection neuron. It collects sonar features one per handshake into the 960-bit parallel `uzorak` bus. It then freezes the bus while the neuron pipeline settles, captures the neuron's 16-bit probability, and presents it downstream with a valid/ready handshake. It is the producer end of the neuron's `uzorak` input and the consumer end of its `izlaz` output.

## Interface
Parameters:
- `N_FEAT`, 60: features per sample.
- `W`, 16: feature and probability width.
- `LATENCY`, 3: clock edges from a stable `uzorak` to a valid neuron `izlaz`.
- `THRESHOLD`, 16'h8000: mine decision threshold (see Configuration).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `feat_data` in W: one feature, unsigned fixed point.
- `feat_valid` in 1: `feat_data` is valid.
- `feat_ready` out 1: loader accepts a feature this cycle.
- `uzorak` out N_FEAT*W: packed sample to the neuron. Feature k sits at [W*k+W-1 : W*k].
- `neuron_izlaz` in W: neuron probability output.
- `res_data` out W: captured probability.
- `res_valid` out 1: `res_data` is valid.
- `res_ready` in 1: downstream accepts the result.
- `busy` out 1: a sample is in progress.
- `mina` out 1: mine decision bit.

## Operation
- FSM states: LOAD, WAIT, OUT.
- LOAD:
  - `feat_ready`=1.
  - On `feat_valid`&`feat_ready`, write `feat_data` into slot `idx`, then `idx`++.
  - On accepting slot N_FEAT-1: go to WAIT, set `cnt`=0, set `idx`=0.
- WAIT:
  - `feat_ready`=0 and `uzorak` is frozen.
  - `cnt` increments each cycle.
  - In the cycle where `cnt`==LATENCY: capture `neuron_izlaz` into `res_data`, set `res_valid`=1, go to OUT.
- OUT:
  - `res_valid`=1; `res_data` and `uzorak` are held.
  - On `res_valid`&`res_ready`: clear `res_valid` and go to LOAD.
- `feat_valid` is ignored in WAIT and OUT. `res_ready` is ignored when `res_valid`=0.
- `uzorak` is never cleared between samples. Slots are overwritten in place; the neuron output during LOAD is don't-care.
- `busy` = (state != LOAD) | (`idx` != 0).
- `idx` counts 0..N_FEAT-1 and is clog2(N_FEAT) bits wide. It never wraps past N_FEAT-1.
- `cnt` is clog2(LATENCY+1) bits wide.

## Timing
- Reset values: `uzorak`=0, `res_data`=0, `res_valid`=0, `busy`=0, `mina`=0. State=LOAD, `idx`=0, `cnt`=0.
- `feat_ready`=0 while `rst`=1, and 1 in the first cycle after `rst` deasserts.
- Let edge E0 accept the last feature. `res_valid` rises at edge E(LATENCY+1), i.e. E4 by default. The capture at that edge samples `neuron_izlaz` as settled after E3.
- Best-case throughput: N_FEAT + LATENCY + 2 cycles per sample with `res_ready` tied high.
- `feat_ready` is 0 in the cycle after E0.
- The first feature of the next sample is accepted no earlier than the cycle after the `res_valid`&`res_ready` edge.
- Reset mid-operation, in any state: the partial sample or pending result is discarded and all reset values above are restored at that edge.
- `res_ready` held low: `res_valid`, `res_data` and `uzorak` stay stable indefinitely.

## Configuration
- Macro `SAMPLE_LOADER_DECISION_EN`.
- Defined: `mina` is registered at the `res_data` capture edge as (`neuron_izlaz` >= THRESHOLD), unsigned comparison. It is held with `res_data` and cleared on handshake and on reset.
- Undefined: `mina` is a constant 0 and no comparator is built.

## Structure
- Shared package `sample_loader_pkg` holds:
  - N_FEAT=60, W=16, NEURON_LATENCY=3, DECISION_THRESHOLD=16'h8000.
  - The state enum LOAD/WAIT/OUT.
  - The derived widths IDX_W and CNT_W.
- No sub-module is needed. The neuron is instantiated alongside the loader in the top level, not inside it.

## Test plan
- Full sample load:
  - Stimulus: feature k = k+1 for k=0..59, `feat_valid` held high.
  - Response: `uzorak`[15:0]=16'h0001, `uzorak`[959:944]=16'h003C, and `feat_ready`=0 the cycle after the 60th accept.
- Latency:
  - Stimulus: the neuron model drives `neuron_izlaz`=16'hA5A5 three edges after a stable `uzorak`.
  - Response: `res_valid` rises exactly 4 edges after the last accept, with `res_data`=16'hA5A5.
- Backpressure:
  - Stimulus: `res_ready`=0 for 10 cycles, then 1.
  - Response: `res_valid` and `res_data` are held for all 10 cycles, `feat_ready` stays 0, and LOAD resumes with `idx`=0 the cycle after the handshake.
- Gapped input:
  - Stimulus: `feat_valid` toggled 1/0 each cycle.
  - Response: slots fill in order with no skips, and the last accept falls at cycle 119.
- Mid-load reset:
  - Stimulus: `rst` pulsed for 1 cycle after 30 features are loaded.
  - Response: `uzorak`=0 and `busy`=0. A fresh 60-feature load then completes normally.
- Decision, with the macro defined:
  - Stimulus: `neuron_izlaz`=16'h8000, then 16'h7FFF on a second sample.
  - Response: `mina`=1 for the first result and 0 for the second.
  - Without the macro, `mina` stays 0 for both.

Source files
------------

// File: rtl/sample_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : sample_loader_pkg
// Brief  : Shared constants, derived widths and FSM state type for sample_loader.
// Rev    : 1.0  initial release
// ============================================================================
package sample_loader_pkg;

  localparam int          N_FEAT             = 60;
  localparam int          W                  = 16;
  localparam int          NEURON_LATENCY     = 3;
  localparam logic [15:0] DECISION_THRESHOLD = 16'h8000;

  localparam int IDX_W = $clog2(N_FEAT);
  localparam int CNT_W = $clog2(NEURON_LATENCY + 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sample_loader.sv
`default_nettype none
// ============================================================================
// Module : sample_loader
// Brief  : Serial-to-parallel feature loader for the sonar neuron; freezes the
//          sample bus for the neuron latency, then hands the probability on.
//          Optional mine decision output: define SAMPLE_LOADER_DECISION_EN.
// Rev    : 1.0  initial release
// ============================================================================
module sample_loader
  import sample_loader_pkg::*;
#(
  parameter int          N_FEAT    = sample_loader_pkg::N_FEAT,
  parameter int          W         = sample_loader_pkg::W,
  parameter int          LATENCY   = sample_loader_pkg::NEURON_LATENCY,
  parameter logic [15:0] THRESHOLD = sample_loader_pkg::DECISION_THRESHOLD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          feat_data,
  input  logic                  feat_valid,
  output logic                  feat_ready,
  output logic [N_FEAT*W-1:0]   uzorak,
  input  logic [W-1:0]          neuron_izlaz,
  output logic [W-1:0]          res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  mina
);

  localparam int                 c_IDX_W    = $clog2(N_FEAT);
  localparam int                 c_CNT_W    = $clog2(LATENCY + 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_FEAT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_CAP  = c_CNT_W'(LATENCY);

  state_e               state_q;
  logic [c_IDX_W-1:0]   idx_q;
  logic [c_CNT_W-1:0]   cnt_q;
  logic [N_FEAT*W-1:0]  uzorak_q;
  logic [W-1:0]         res_data_q;
  logic                 res_valid_q;
  logic                 w_capture;

  // Ready is gated by reset so nothing is offered while the block is held.
  assign feat_ready = (state_q == LOAD) && !rst;
  assign w_capture  = (state_q == WAIT) && (cnt_q == c_CNT_CAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      uzorak_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (feat_valid) begin
            for (int k = 0; k < N_FEAT; k++) begin
              if (idx_q == c_IDX_W'(k)) uzorak_q[k*W +: W] <= feat_data;
            end
            if (idx_q == c_IDX_LAST) begin
              state_q <= WAIT;
              cnt_q   <= '0;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + c_IDX_W'(1);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + c_CNT_W'(1);
          if (w_capture) begin
            res_data_q  <= neuron_izlaz;
            res_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign uzorak    = uzorak_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != LOAD) || (idx_q != '0);

`ifdef SAMPLE_LOADER_DECISION_EN
  logic mina_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mina_q <= 1'b0;
    end else if (w_capture) begin
      mina_q <= (neuron_izlaz >= W'(THRESHOLD));
    end else if ((state_q == OUT) && res_ready) begin
      mina_q <= 1'b0;
    end
  end

  assign mina = mina_q;
`else
  logic [15:0] w_unused_thr;
  assign w_unused_thr = THRESHOLD;
  assign mina         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_sample_loader
// Brief  : Self-checking bench for sample_loader with a 3-stage neuron model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sample_loader;

  localparam int NF = 60;
  localparam int FW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FW-1:0]     feat_data = '0;
  logic              feat_valid = 1'b0;
  logic              feat_ready;
  logic [NF*FW-1:0]  uzorak;
  logic [FW-1:0]     neuron_izlaz = '0;
  logic [FW-1:0]     res_data;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic              busy;
  logic              mina;

  always #5 clk = ~clk;

  sample_loader dut (
    .clk          (clk),
    .rst          (rst),
    .feat_data    (feat_data),
    .feat_valid   (feat_valid),
    .feat_ready   (feat_ready),
    .uzorak       (uzorak),
    .neuron_izlaz (neuron_izlaz),
    .res_data     (res_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .busy         (busy),
    .mina         (mina)
  );

  // Neuron stand-in: XOR of all features, three registered stages deep.
  logic [FW-1:0] n1 = '0;
  logic [FW-1:0] n2 = '0;
  always @(posedge clk) begin
    n1           <= fold_bus(uzorak);
    n2           <= n1;
    neuron_izlaz <= n2;
  end

  logic [FW-1:0] feats  [NF];
  logic [FW-1:0] m_slot [NF];
  logic          dir_en  = 1'b0;
  logic [FW-1:0] dir_res = '0;
  int            n_vec = 0;
  int            n_err = 0;
  int            lc;

  function automatic logic [FW-1:0] fold_bus(input logic [NF*FW-1:0] v);
    logic [FW-1:0] a = '0;
    for (int i = 0; i < NF; i++) a ^= v[i*FW +: FW];
    return a;
  endfunction

  function automatic logic [FW-1:0] model_xor();
    logic [FW-1:0] a = '0;
    for (int i = 0; i < NF; i++) a ^= m_slot[i];
    return a;
  endfunction

  function automatic logic [NF*FW-1:0] model_bus();
    logic [NF*FW-1:0] p;
    for (int i = 0; i < NF; i++) p[i*FW +: FW] = m_slot[i];
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic rand_feats();
    for (int i = 0; i < NF; i++) feats[i] = 16'($urandom);
  endtask

  // Random sample whose feature XOR (the neuron result) equals target.
  task automatic target_feats(input logic [FW-1:0] target);
    logic [FW-1:0] a = '0;
    for (int i = 0; i < NF - 1; i++) begin
      feats[i] = 16'($urandom);
      a ^= feats[i];
    end
    feats[NF-1] = target ^ a;
  endtask

  // gap_mode: 0 valid every cycle, 1 alternating 1/0, 2 random.
  task automatic load_feats(input int n, input int gap_mode, output int last_cyc);
    int   k = 0;
    int   cyc = 0;
    logic fv;
    last_cyc = -1;
    while (k < n && cyc < 4000) begin
      check("feat_ready_load", 64'(feat_ready), 64'(1));
      case (gap_mode)
        0:       fv = 1'b1;
        1:       fv = (cyc % 2 == 0);
        default: fv = 1'($urandom_range(0, 1));
      endcase
      feat_valid = fv;
      feat_data  = fv ? feats[k] : 16'($urandom);
      @(posedge clk); #1;
      if (fv) begin
        m_slot[k] = feats[k];
        check("slot_write", 64'(uzorak[k*FW +: FW]), 64'(feats[k]));
        k++;
        last_cyc = cyc + 1;
      end
      check("busy_load", 64'(busy), 64'(k != 0));
      cyc++;
    end
    check("load_done", 64'(k), 64'(n));
    feat_valid = 1'b0;
  endtask

  // Entered one step after the edge that accepted the last feature (E0).
  task automatic finish_sample(input int hold);
    logic [FW-1:0] exp_res;
    logic          exp_m;
    exp_res = model_xor();
`ifdef SAMPLE_LOADER_DECISION_EN
    exp_m = (exp_res >= 16'h8000);
`else
    exp_m = 1'b0;
`endif
    check("ready_after_last", 64'(feat_ready), 64'(0));
    check("uzorak_full", 64'(uzorak === model_bus()), 64'(1));
    for (int e = 1; e <= 3; e++) begin
      feat_valid = 1'($urandom_range(0, 1));
      feat_data  = 16'($urandom);
      res_ready  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("res_valid_wait", 64'(res_valid), 64'(0));
      check("feat_ready_wait", 64'(feat_ready), 64'(0));
    end
    feat_valid = 1'($urandom_range(0, 1));
    res_ready  = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check("res_valid_E4", 64'(res_valid), 64'(1));
    check("res_data", 64'(res_data), 64'(exp_res));
    check("mina", 64'(mina), 64'(exp_m));
    check("busy_out", 64'(busy), 64'(1));
    if (dir_en) check("res_directed", 64'(res_data), 64'(dir_res));
    res_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      feat_valid = 1'($urandom_range(0, 1));
      feat_data  = 16'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 64'(res_valid), 64'(1));
      check("hold_data", 64'(res_data), 64'(exp_res));
      check("hold_ready", 64'(feat_ready), 64'(0));
      check("hold_mina", 64'(mina), 64'(exp_m));
      check("hold_uzorak", 64'(uzorak === model_bus()), 64'(1));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready  = 1'b0;
    feat_valid = 1'b0;
    check("valid_after_hs", 64'(res_valid), 64'(0));
    check("ready_after_hs", 64'(feat_ready), 64'(1));
    check("busy_after_hs", 64'(busy), 64'(0));
    check("mina_after_hs", 64'(mina), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < NF; i++) m_slot[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(feat_ready), 64'(0));
    check("rst_uzorak", 64'(uzorak === '0), 64'(1));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mina", 64'(mina), 64'(0));
    rst = 1'b0;
    #1;
    check("ready_post_rst", 64'(feat_ready), 64'(1));

    // Ramp sample: feature k = k+1.
    for (int i = 0; i < NF; i++) feats[i] = 16'(i + 1);
    load_feats(NF, 0, lc);
    check("ramp_slot0", 64'(uzorak[15:0]), 64'h0001);
    check("ramp_slot59", 64'(uzorak[959:944]), 64'h003C);
    finish_sample(0);

    // Latency with a known neuron result.
    target_feats(16'hA5A5);
    dir_en = 1'b1; dir_res = 16'hA5A5;
    load_feats(NF, 0, lc);
    finish_sample(0);
    dir_en = 1'b0;

    // Backpressure for 10 cycles.
    rand_feats();
    load_feats(NF, 0, lc);
    finish_sample(10);

    // Gapped input.
    rand_feats();
    load_feats(NF, 1, lc);
    check("last_accept_cycle", 64'(lc), 64'(119));
    finish_sample(0);

    // Mid-load reset after 30 features.
    rand_feats();
    load_feats(30, 0, lc);
    rst = 1'b1;
    #1;
    check("ready_in_rst", 64'(feat_ready), 64'(0));
    @(posedge clk); #1;
    for (int i = 0; i < NF; i++) m_slot[i] = '0;
    check("midrst_uzorak", 64'(uzorak === '0), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_valid", 64'(res_valid), 64'(0));
    rst = 1'b0;
    #1;
    check("midrst_ready", 64'(feat_ready), 64'(1));
    rand_feats();
    load_feats(NF, 0, lc);
    finish_sample(0);

    // Decision threshold boundary.
    target_feats(16'h8000);
    dir_en = 1'b1; dir_res = 16'h8000;
    load_feats(NF, 0, lc);
    finish_sample(1);
    target_feats(16'h7FFF);
    dir_res = 16'h7FFF;
    load_feats(NF, 0, lc);
    finish_sample(0);
    dir_en = 1'b0;

    // Random traffic.
    for (int s = 0; s < 6; s++) begin
      rand_feats();
      load_feats(NF, 2, lc);
      finish_sample($urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
